// File: rtl/serial_word_tx_if.sv
// Load handshake and serial output bundle for serial_word_tx.
// The master drives words in; the slave (the transmitter) drives the serial stream out.
interface serial_word_tx_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             neg;
  logic             y;
  logic             frame;
  logic             sof;
  logic             eof;
  logic             busy;

  modport master (
    output load_valid, data_in, neg,
    input  load_ready, y, frame, sof, eof, busy
  );

  modport slave (
    input  load_valid, data_in, neg,
    output load_ready, y, frame, sof, eof, busy
  );
endinterface

// File: rtl/serial_word_tx.sv
// LSB-first serial word transmitter with optional on-the-fly two's complement.
// Negation is done serially: pass bits up to the first 1, then invert the rest.
module serial_word_tx #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  r,
  serial_word_tx_if.slave       bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             neg_q, neg_d;
  logic             seen_q, seen_d;
  logic             y_q, y_d;
  logic             frame_q, frame_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic             last_s;
  logic             ready_s;
  logic             accept_s;

  // Serial two's complement: a bit is inverted once an earlier 1 has gone out.
  function automatic logic tx_bit(input logic data_bit, input logic neg_bit, input logic seen_bit);
    return data_bit ^ (neg_bit & seen_bit);
  endfunction

  assign last_s   = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
  assign ready_s  = ~r & ((state_q == S_IDLE) | last_s);
  assign accept_s = bus.load_valid & ready_s;

  // Next-state decode for the FSM, datapath and the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    neg_d   = neg_q;
    seen_d  = seen_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_ZERO;
          shreg_d = bus.data_in;
          neg_d   = bus.neg;
          seen_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          shreg_d = {WIDTH{1'b0}};
          neg_d   = 1'b0;
          seen_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        if (last_s) begin
          if (accept_s) begin
            state_d = S_SHIFT;
            cnt_d   = CNT_ZERO;
            shreg_d = bus.data_in;
            neg_d   = bus.neg;
            seen_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            shreg_d = {WIDTH{1'b0}};
            neg_d   = 1'b0;
            seen_d  = 1'b0;
          end
        end else begin
          state_d = S_SHIFT;
          cnt_d   = cnt_q + CW'(1);
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          neg_d   = neg_q;
          seen_d  = seen_q | shreg_q[0];
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        shreg_d = {WIDTH{1'b0}};
        neg_d   = 1'b0;
        seen_d  = 1'b0;
      end
    endcase

    // Outputs describe the bit that will be on the line after this edge.
    frame_d = (state_d == S_SHIFT);
    y_d     = frame_d & tx_bit(shreg_d[0], neg_d, seen_d);
    sof_d   = frame_d & (cnt_d == CNT_ZERO);
    eof_d   = frame_d & (cnt_d == CNT_LAST);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      shreg_q <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      seen_q  <= 1'b0;
      y_q     <= 1'b0;
      frame_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      neg_q   <= neg_d;
      seen_q  <= seen_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign bus.load_ready = ready_s;
  assign bus.y          = y_q;
  assign bus.frame      = frame_q;
  assign bus.sof        = sof_q;
  assign bus.eof        = eof_q;
  assign bus.busy       = frame_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: a bit-queue model of the transmitted stream,
// directed vectors with known serial patterns, then random traffic.
module tb_serial_word_tx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic r;
  always #5 clk = ~clk;

  serial_word_tx_if #(.WIDTH(W)) bus ();

  serial_word_tx #(.WIDTH(W)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  typedef struct packed {
    logic y;
    logic sof;
    logic eof;
  } exp_t;

  exp_t        expq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] capv;
  int          ncap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word actually put on the line: value or its negation modulo 2^W.
  function automatic logic [W-1:0] tx_word(input logic [W-1:0] d, input logic n);
    int unsigned m;
    int unsigned v;
    m = 32'd1 << W;
    v = n ? ((m - int'(d)) % m) : int'(d);
    return v[W-1:0];
  endfunction

  task automatic push_word(input logic [W-1:0] d, input logic n);
    logic [W-1:0] w;
    w = tx_word(d, n);
    for (int k = 0; k < W; k++)
      expq.push_back('{y: w[k], sof: (k == 0), eof: (k == W - 1)});
  endtask

  // One clock cycle: check outputs mid-cycle, drive inputs, advance the model.
  task automatic step(input logic lv, input logic [W-1:0] d, input logic n);
    exp_t e;
    logic rdy;
    logic act;
    @(negedge clk);
    rdy = (expq.size() <= 1);
    act = (expq.size() > 0);
    e   = act ? expq[0] : '0;
    chk("frame", bus.frame, act);
    chk("busy", bus.busy, act);
    chk("y", bus.y, e.y);
    chk("sof", bus.sof, e.sof);
    chk("eof", bus.eof, e.eof);
    chk("load_ready", bus.load_ready, rdy);
    if (bus.frame === 1'b1 && ncap < 64) begin
      capv[ncap] = bus.y;
      ncap++;
    end
    bus.load_valid = lv;
    bus.data_in    = d;
    bus.neg        = n;
    @(posedge clk);
    if (expq.size() > 0) void'(expq.pop_front());
    if (lv && rdy) push_word(d, n);
  endtask

  task automatic idle_step();
    step(1'b0, W'($urandom), 1'($urandom));
  endtask

  task automatic cap_clr();
    ncap = 0;
    capv = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_y"}, bus.y, 0);
    chk({tag, "_frame"}, bus.frame, 0);
    chk({tag, "_sof"}, bus.sof, 0);
    chk({tag, "_eof"}, bus.eof, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ready"}, bus.load_ready, 0);
  endtask

  // Single word with idle around it; serial pattern compared to a fixed value.
  task automatic run_word(input logic [W-1:0] d, input logic n, input logic [W-1:0] pattern);
    cap_clr();
    step(1'b1, d, n);
    repeat (W + 1) idle_step();
    chk($sformatf("pattern_%0h_%0d", d, n), capv[W-1:0], pattern);
    chk($sformatf("bits_%0h_%0d", d, n), ncap, W);
  endtask

  initial begin
    r              = 1'b1;
    bus.load_valid = 1'b0;
    bus.data_in    = '0;
    bus.neg        = 1'b0;
    cap_clr();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    r = 1'b0;

    // First acceptance right at the first edge after reset release.
    run_word(8'h0B, 1'b0, 8'h0B);
    run_word(8'h0C, 1'b1, 8'hF4);
    run_word(8'h00, 1'b1, 8'h00);
    run_word(8'h80, 1'b1, 8'h80);

    // load_valid held high across two words: back-to-back, no gap.
    cap_clr();
    step(1'b1, 8'hA5, 1'b0);
    repeat (8) step(1'b1, 8'h3C, 1'b1);
    repeat (9) idle_step();
    chk("b2b_pattern", capv[15:0], 16'hC4A5);
    chk("b2b_bits", ncap, 16);

    // Reset during bit 4 of 0xFF aborts the word.
    step(1'b1, 8'hFF, 1'b0);
    repeat (4) idle_step();
    @(negedge clk);
    bus.load_valid = 1'b0;
    #1 r = 1'b1;
    #1 chk_all_zero("abort");
    @(posedge clk);
    #1 chk_all_zero("abort_hold");
    r = 1'b0;
    expq.delete();
    run_word(8'h01, 1'b1, 8'hFF);

    // Load offered mid-word (cnt = 2) is ignored.
    cap_clr();
    step(1'b1, 8'h96, 1'b0);
    repeat (2) idle_step();
    step(1'b1, 8'h55, 1'b0);
    repeat (6) idle_step();
    chk("ignored_pattern", capv[7:0], 8'h96);
    chk("ignored_bits", ncap, 8);

    repeat (400) step(($urandom_range(0, 2) == 0), W'($urandom), 1'($urandom));
    repeat (W + 2) idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter: WIDTH, default 8, bits per word (legal range 2..32).
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: r  input  1  reset, asynchronous, active-high; forces the reset state immediately on assertion, independent of clk.
REQ-004 Port: load_valid  input  1  parallel word offered for transmission.
REQ-005 Port: load_ready  output  1  block accepts a word at this clk edge when load_valid is also high.
REQ-006 Port: data_in  input  WIDTH  parallel word, sampled at acceptance.
REQ-007 Port: neg  input  1  sampled at acceptance; 1 = transmit the two's complement of data_in, 0 = transmit data_in unchanged.
REQ-008 Port: y  output  1  serial data bit, LSB first.
REQ-009 Port: frame  output  1  high in every cycle that y carries a valid bit.
REQ-010 Port: sof  output  1  high only during bit 0 of a word.
REQ-011 Port: eof  output  1  high only during bit WIDTH-1 of a word.
REQ-012 Port: busy  output  1  high while a word is in transmission (equals frame).

Function
REQ-013 States: IDLE (no word held), SHIFT (transmitting); a bit counter cnt runs 0..WIDTH-1.
REQ-014 Acceptance: at a clk edge with load_valid=1 and load_ready=1, the block captures data_in into a shift register, captures neg, clears cnt and the seen-one flag, and enters SHIFT.
REQ-015 load_ready = 1 in IDLE; = 1 in SHIFT only when cnt = WIDTH-1 (last bit); 0 otherwise; forced 0 while r is high.
REQ-016 Latency: bit k of the accepted word appears on y in the (k+1)th cycle after the acceptance edge, one bit per cycle, no gaps.
REQ-017 neg=0: y = shreg[0] for each bit.
REQ-018 neg=1: y = shreg[0] XOR seen, where seen = 1 once any earlier bit of the same word was 1 (pass bits up to and including the first 1, invert all later bits); seen updates after each bit.
REQ-019 seen and neg are per word; both are reloaded at every acceptance and never carry over between words.
REQ-020 After the cycle with cnt = WIDTH-1: if a word is accepted at that edge, SHIFT continues with the new word's bit 0 in the next cycle (back-to-back, sof high, no idle cycle); otherwise return to IDLE.
REQ-021 In IDLE: y, frame, sof, eof, busy = 0.
REQ-022 load_valid while load_ready = 0 is ignored; data_in and neg changes mid-word do not affect the word in flight.
REQ-023 Arithmetic is modulo 2^WIDTH: neg=1 with data_in = 0 transmits all zeros; with data_in = 2^(WIDTH-1) transmits the same pattern unchanged.

Reset
REQ-024 While r is high: state IDLE, cnt = 0, shift register = 0, seen = 0, neg register = 0; y, frame, sof, eof, busy, load_ready = 0.
REQ-025 Assertion of r mid-word aborts the word immediately; no partial bits are emitted after r deasserts; the first word accepted after reset starts at bit 0 with seen = 0.
REQ-026 First acceptance is possible at the first clk edge after r deasserts.

Verification (WIDTH=8)
REQ-027 Load 0x0B, neg=0 -> y over cycles 1..8 = 1,1,0,1,0,0,0,0; sof in cycle 1, eof in cycle 8, frame high in cycles 1..8, IDLE in cycle 9.
REQ-028 Load 0x0C, neg=1 -> y = 0,0,1,0,1,1,1,1 (0xF4 LSB first).
REQ-029 Load 0x00, neg=1 -> eight zeros; load 0x80, neg=1 -> 0,0,0,0,0,0,0,1.
REQ-030 load_valid held high with 0xA5 (neg=0) then 0x3C (neg=1) -> 16 contiguous frame cycles, sof in cycles 1 and 9, eof in cycles 8 and 16, y = 1,0,1,0,0,1,0,1, 0,0,1,0,0,0,1,1.
REQ-031 Pulse r during bit 4 of 0xFF -> all outputs 0 immediately and load_ready = 0 while r is high; then load 0x01, neg=1 -> y = 1,1,1,1,1,1,1,1.
REQ-032 load_valid pulsed with 0x55 while cnt = 2 of an in-flight word -> ignored; the in-flight word completes unchanged and the block returns to IDLE.
